// File: rtl/ysyx_20020207_clint_pkg.sv
// Shared definitions for the CLINT/RTC responder: region addresses,
// AXI response codes, FSM state types and the byte-lane merge helper.
package ysyx_20020207_clint_pkg;

  localparam logic [31:0] RTC_ADDR      = 32'ha000_0048;
  localparam logic [31:0] RTC_ADDR_HIGH = 32'ha000_004c;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  // Replace only the strobed bytes of a 32-bit word; unstrobed bytes keep old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_20020207_clint_if.sv
// AXI-lite style bus between crossbar port 2 and the CLINT/RTC responder.
interface ysyx_20020207_clint_if;

  logic        arvalid;
  logic [31:0] araddr;
  logic        high;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic        wvalid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, high, rready,
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, high, rready,
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/ysyx_20020207_mtime_counter.sv
// Free-running 64-bit mtime with a cycle prescaler and a byte-lane
// preload port. A preload wins over the increment of the same cycle.
module ysyx_20020207_mtime_counter
  import ysyx_20020207_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_high,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic [63:0] mtime
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [63:0]     mtime_r;
  logic [PS_W-1:0] prescale_r;

  // Counter state: reset, preload (restarting the prescaler), or tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime_r    <= 64'd0;
      prescale_r <= {PS_W{1'b0}};
    end else if (wr_en) begin
      prescale_r <= {PS_W{1'b0}};
      if (wr_high) begin
        mtime_r[63:32] <= merge_lanes(mtime_r[63:32], wr_data[63:32], wr_strb[7:4]);
      end else begin
        mtime_r[31:0]  <= merge_lanes(mtime_r[31:0], wr_data[31:0], wr_strb[3:0]);
      end
    end else if (prescale_r == PS_LAST) begin
      prescale_r <= {PS_W{1'b0}};
      mtime_r    <= mtime_r + 64'd1;
    end else begin
      prescale_r <= prescale_r + PS_W'(1);
    end
  end

  assign mtime = mtime_r;

endmodule

// File: rtl/ysyx_20020207_clint.sv
// CLINT/RTC responder: serves 32-bit reads of the mtime low/high word
// (duplicated on both halves of the 64-bit bus) and accepts byte-lane
// preloads. A low-word read snapshots the high word so that a
// low-then-high read pair is coherent.
module ysyx_20020207_clint
  import ysyx_20020207_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_20020207_clint_if.slave         bus
);

  logic [63:0] mtime_s;

  // Read channel state
  rd_state_e   rd_state_r, rd_state_s;
  logic        arready_r,  arready_s;
  logic        rvalid_r,   rvalid_s;
  logic [63:0] rdata_r,    rdata_s;
  logic [1:0]  rresp_r,    rresp_s;
  logic [31:0] hi_snap_r,  hi_snap_s;
  logic [31:0] rd_word_s;

  // Write channel state; a low ready flag in W_IDLE means that half is latched
  wr_state_e   wr_state_r, wr_state_s;
  logic        awready_r,  awready_s;
  logic        wready_r,   wready_s;
  logic        bvalid_r,   bvalid_s;
  logic [1:0]  bresp_r,    bresp_s;
  logic        aw_hi_r,    aw_hi_s;
  logic [63:0] wdata_r,    wdata_s;
  logic [7:0]  wstrb_r,    wstrb_s;
  logic        wr_en_s;

  // The crossbar has already decoded the region; only awaddr[2] selects a word.
  logic unused_addr_s;
  assign unused_addr_s = ^{bus.araddr, bus.awaddr[31:3], bus.awaddr[1:0]};

  ysyx_20020207_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_high (aw_hi_r),
    .wr_data (wdata_r),
    .wr_strb (wstrb_r),
    .mtime   (mtime_s)
  );

  // Read FSM next state: capture on AR handshake, hold data until rready.
  always_comb begin
    rd_state_s = rd_state_r;
    arready_s  = arready_r;
    rvalid_s   = rvalid_r;
    rdata_s    = rdata_r;
    rresp_s    = rresp_r;
    hi_snap_s  = hi_snap_r;
    rd_word_s  = 32'd0;
    case (rd_state_r)
      R_IDLE: begin
        if (bus.arvalid && arready_r) begin
          if (bus.high) begin
            rd_word_s = hi_snap_r;
          end else begin
            rd_word_s = mtime_s[31:0];
            hi_snap_s = mtime_s[63:32];
          end
          rdata_s    = {rd_word_s, rd_word_s};
          rresp_s    = RESP_OKAY;
          rvalid_s   = 1'b1;
          arready_s  = 1'b0;
          rd_state_s = R_DATA;
        end else begin
          arready_s  = 1'b1;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          rvalid_s   = 1'b0;
          arready_s  = 1'b1;
          rd_state_s = R_IDLE;
        end else begin
          rvalid_s   = 1'b1;
          arready_s  = 1'b0;
        end
      end
      default: begin
        rd_state_s = R_IDLE;
        arready_s  = 1'b1;
        rvalid_s   = 1'b0;
      end
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rdata_r    <= 64'd0;
      rresp_r    <= 2'b00;
      hi_snap_r  <= 32'd0;
    end else begin
      rd_state_r <= rd_state_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rdata_r    <= rdata_s;
      rresp_r    <= rresp_s;
      hi_snap_r  <= hi_snap_s;
    end
  end

  // Write FSM next state: latch AW and W independently, commit once both are held.
  always_comb begin
    wr_state_s = wr_state_r;
    awready_s  = awready_r;
    wready_s   = wready_r;
    bvalid_s   = bvalid_r;
    bresp_s    = bresp_r;
    aw_hi_s    = aw_hi_r;
    wdata_s    = wdata_r;
    wstrb_s    = wstrb_r;
    wr_en_s    = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (!awready_r && !wready_r) begin
          wr_en_s    = 1'b1;
          bvalid_s   = 1'b1;
          bresp_s    = RESP_OKAY;
          wr_state_s = W_RESP;
        end else begin
          if (bus.awvalid && awready_r) begin
            aw_hi_s   = bus.awaddr[2];
            awready_s = 1'b0;
          end else begin
            aw_hi_s   = aw_hi_r;
          end
          if (bus.wvalid && wready_r) begin
            wdata_s  = bus.wdata;
            wstrb_s  = bus.wstrb;
            wready_s = 1'b0;
          end else begin
            wdata_s  = wdata_r;
          end
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_s   = 1'b0;
          awready_s  = 1'b1;
          wready_s   = 1'b1;
          wr_state_s = W_IDLE;
        end else begin
          bvalid_s   = 1'b1;
        end
      end
      default: begin
        wr_state_s = W_IDLE;
        awready_s  = 1'b1;
        wready_s   = 1'b1;
        bvalid_s   = 1'b0;
      end
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      aw_hi_r    <= 1'b0;
      wdata_r    <= 64'd0;
      wstrb_r    <= 8'd0;
    end else begin
      wr_state_r <= wr_state_s;
      awready_r  <= awready_s;
      wready_r   <= wready_s;
      bvalid_r   <= bvalid_s;
      bresp_r    <= bresp_s;
      aw_hi_r    <= aw_hi_s;
      wdata_r    <= wdata_s;
      wstrb_r    <= wstrb_s;
    end
  end

  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = bresp_r;

endmodule

// File: tb/tb_ysyx_20020207_clint.sv
// Directed bench for the CLINT/RTC responder (TICK_DIV=1). Inputs change
// and outputs are sampled on the falling edge; expected values are
// hand-computed from the cycle in which each read captures mtime.
module tb_ysyx_20020207_clint;
  import ysyx_20020207_clint_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ysyx_20020207_clint_if bus_if ();

  ysyx_20020207_clint #(
    .TICK_DIV (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; AR handshake on the next rising edge.
  task automatic do_read(input logic hi, input int hold, input logic [63:0] exp);
    chk("rd_pre_arready", bus_if.arready, 64'd1);
    chk("rd_pre_rvalid", bus_if.rvalid, 64'd0);
    bus_if.arvalid = 1'b1;
    bus_if.high    = hi;
    bus_if.araddr  = hi ? RTC_ADDR_HIGH : RTC_ADDR;
    @(negedge clk);
    bus_if.arvalid = 1'b0;
    chk("rd_rvalid", bus_if.rvalid, 64'd1);
    chk("rd_arready_busy", bus_if.arready, 64'd0);
    chk("rd_rresp", bus_if.rresp, 64'd0);
    chk("rd_rdata", bus_if.rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rd_hold_rvalid", bus_if.rvalid, 64'd1);
      chk("rd_hold_rdata", bus_if.rdata, exp);
      chk("rd_hold_arready", bus_if.arready, 64'd0);
    end
    bus_if.rready = 1'b1;
    @(negedge clk);
    bus_if.rready = 1'b0;
    chk("rd_done_rvalid", bus_if.rvalid, 64'd0);
    chk("rd_done_arready", bus_if.arready, 64'd1);
  endtask

  // AW and W together; commit on the second edge, B accepted on the third.
  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    bus_if.awaddr  = addr;
    bus_if.wdata   = data;
    bus_if.wstrb   = strb;
    @(negedge clk);
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    chk("wr_awready_low", bus_if.awready, 64'd0);
    chk("wr_wready_low", bus_if.wready, 64'd0);
    chk("wr_bvalid_early", bus_if.bvalid, 64'd0);
    @(negedge clk);
    chk("wr_bvalid", bus_if.bvalid, 64'd1);
    chk("wr_bresp", bus_if.bresp, 64'd0);
    bus_if.bready = 1'b1;
    @(negedge clk);
    bus_if.bready = 1'b0;
    chk("wr_done_bvalid", bus_if.bvalid, 64'd0);
    chk("wr_done_awready", bus_if.awready, 64'd1);
    chk("wr_done_wready", bus_if.wready, 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.arvalid = 1'b0; bus_if.araddr = 32'd0; bus_if.high = 1'b0; bus_if.rready = 1'b0;
    bus_if.awvalid = 1'b0; bus_if.awaddr = 32'd0; bus_if.wvalid = 1'b0;
    bus_if.wdata = 64'd0; bus_if.wstrb = 8'd0; bus_if.bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", bus_if.arready, 64'd1);
    chk("rst_awready", bus_if.awready, 64'd1);
    chk("rst_wready", bus_if.wready, 64'd1);
    chk("rst_rvalid", bus_if.rvalid, 64'd0);
    chk("rst_bvalid", bus_if.bvalid, 64'd0);
    chk("rst_rdata", bus_if.rdata, 64'd0);
    chk("rst_rresp", bus_if.rresp, 64'd0);
    chk("rst_bresp", bus_if.bresp, 64'd0);
    chk("rst_mtime", dut.mtime_s, 64'd0);
    rst = 1'b1;

    // 10 ticks, then the read captures mtime=10
    repeat (10) @(negedge clk);
    do_read(1'b0, 0, {32'h0000_000A, 32'h0000_000A});

    // High-word preload; increment of the commit cycle is overridden
    do_write(RTC_ADDR_HIGH, {32'h0000_0001, 32'h0000_0000}, 8'hF0);
    do_read(1'b0, 0, {32'h0000_000E, 32'h0000_000E});
    do_read(1'b1, 0, {32'h0000_0001, 32'h0000_0001});

    // Preload 0x00000000_FFFFFFFE; a read captures in the cycle right after commit
    do_write(RTC_ADDR_HIGH, 64'h0, 8'hF0);
    bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1; bus_if.awaddr = RTC_ADDR;
    bus_if.wdata = 64'h0000_0000_FFFF_FFFE; bus_if.wstrb = 8'h0F;
    @(negedge clk);
    bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
    @(negedge clk);
    chk("pre_bvalid", bus_if.bvalid, 64'd1);
    bus_if.bready = 1'b1; bus_if.arvalid = 1'b1; bus_if.high = 1'b0; bus_if.araddr = RTC_ADDR;
    @(negedge clk);
    bus_if.bready = 1'b0; bus_if.arvalid = 1'b0;
    chk("pre_bvalid_done", bus_if.bvalid, 64'd0);
    chk("pre_rvalid", bus_if.rvalid, 64'd1);
    chk("pre_rdata_low", bus_if.rdata, 64'hFFFF_FFFE_FFFF_FFFE);
    bus_if.rready = 1'b1;
    @(negedge clk);
    bus_if.rready = 1'b0;
    chk("pre_rvalid_done", bus_if.rvalid, 64'd0);
    repeat (3) @(negedge clk);
    do_read(1'b1, 0, 64'h0);                                   // snapshot, not the carried 1
    do_read(1'b0, 0, {32'h0000_0005, 32'h0000_0005});          // carry happened
    do_read(1'b1, 0, {32'h0000_0001, 32'h0000_0001});

    // Back-pressure: rready held low for 5 cycles
    do_read(1'b0, 5, {32'h0000_0009, 32'h0000_0009});

    // Nonzero low bytes so a single-byte write shows the others kept
    do_write(RTC_ADDR, {32'h0, 32'h1122_3300}, 8'h0F);

    // W three cycles ahead of AW; a read captures in the commit cycle
    bus_if.wvalid = 1'b1; bus_if.wdata = 64'h0000_0000_0000_00AB; bus_if.wstrb = 8'h01;
    @(negedge clk);
    bus_if.wvalid = 1'b0;
    chk("wfirst_wready", bus_if.wready, 64'd0);
    chk("wfirst_awready", bus_if.awready, 64'd1);
    chk("wfirst_bvalid", bus_if.bvalid, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wfirst_wait_bvalid", bus_if.bvalid, 64'd0);
      chk("wfirst_wait_wready", bus_if.wready, 64'd0);
    end
    bus_if.awvalid = 1'b1; bus_if.awaddr = RTC_ADDR;
    @(negedge clk);
    bus_if.awvalid = 1'b0;
    chk("wfirst_aw_awready", bus_if.awready, 64'd0);
    chk("wfirst_aw_bvalid", bus_if.bvalid, 64'd0);
    bus_if.arvalid = 1'b1; bus_if.high = 1'b0; bus_if.araddr = RTC_ADDR;
    @(negedge clk);
    bus_if.arvalid = 1'b0;
    chk("wfirst_bvalid", bus_if.bvalid, 64'd1);
    chk("wfirst_bresp", bus_if.bresp, 64'd0);
    chk("coincide_rvalid", bus_if.rvalid, 64'd1);
    chk("coincide_prewrite", bus_if.rdata, {32'h1122_3305, 32'h1122_3305});
    bus_if.rready = 1'b1; bus_if.bready = 1'b1;
    @(negedge clk);
    bus_if.rready = 1'b0; bus_if.bready = 1'b0;
    chk("wfirst_done_bvalid", bus_if.bvalid, 64'd0);
    chk("wfirst_done_awready", bus_if.awready, 64'd1);
    chk("wfirst_done_wready", bus_if.wready, 64'd1);
    do_read(1'b0, 0, {32'h1122_33AC, 32'h1122_33AC});

    // Reset while both read data and write response are pending
    bus_if.arvalid = 1'b1; bus_if.high = 1'b0;
    bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1; bus_if.awaddr = RTC_ADDR_HIGH;
    bus_if.wdata = 64'hFFFF_FFFF_FFFF_FFFF; bus_if.wstrb = 8'hFF;
    @(negedge clk);
    bus_if.arvalid = 1'b0; bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", bus_if.rvalid, 64'd1);
    chk("mid_bvalid", bus_if.bvalid, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_rvalid", bus_if.rvalid, 64'd0);
    chk("mrst_bvalid", bus_if.bvalid, 64'd0);
    chk("mrst_arready", bus_if.arready, 64'd1);
    chk("mrst_awready", bus_if.awready, 64'd1);
    chk("mrst_wready", bus_if.wready, 64'd1);
    chk("mrst_rdata", bus_if.rdata, 64'd0);
    chk("mrst_mtime", dut.mtime_s, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
